sd_mem: RTL and testbench

SD_MEM -- requirements
Module: sd_mem

---
 rtl/sd_mem.sv | 189 ++++++++++++++++++
 tb/tb_sd_mem.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_mem.sv
// Single-port word memory with byte/half/word load-store, optional wait states and fault reporting.
// Define SD_MISALIGN_EN to fault misaligned half/word accesses instead of ignoring low address bits.
module sd_mem #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WAIT  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWaits, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;

    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic [AW-1:0] idx;
    logic          oob, bad_size, misal, fault;
    logic [3:0]    be;
    logic [31:0]   wword, rword, load_v;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (WAIT > 0) begin
                        state_d = StWaits;
                        wcnt_d  = 4'(WAIT);
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StWaits: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q <= 4'd1) begin
                    state_d = StAccess;
                    wcnt_d  = '0;
                end
            end
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        ready = (state_q == StIdle) && rst_n;
        ack   = (state_q == StResp);
        rdata = ack ? rdata_q : '0;
        err   = ack & err_q;
    end

    // Request capture happens only on the accepting edge
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sext_d  = sext_q;
        wdata_d = wdata_q;
        if (state_q == StIdle && req) begin
            we_d    = we;
            addr_d  = addr;
            size_d  = size;
            sext_d  = sext;
            wdata_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Address decode, lane enables and load formatting
    always_comb begin
        idx      = addr_q[AW+1:2];
        oob      = |addr_q[31:AW+2];
        bad_size = (size_q == 2'b11);
`ifdef SD_MISALIGN_EN
        misal    = ((size_q == 2'b01) && addr_q[0]) ||
                   ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
        misal    = 1'b0;
`endif
        fault    = oob | bad_size | misal;

        be    = 4'b0000;
        wword = wdata_q;
        case (size_q)
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wword = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata_q[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase

        rword  = mem_q[idx];
        byte_v = rword[{addr_q[1:0], 3'b000} +: 8];
        half_v = addr_q[1] ? rword[31:16] : rword[15:0];
        case (size_q)
            2'b00:   load_v = {{24{sext_q & byte_v[7]}}, byte_v};
            2'b01:   load_v = {{16{sext_q & half_v[15]}}, half_v};
            default: load_v = rword;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (state_q == StAccess) begin
            err_d   = fault;
            rdata_d = (fault || we_q) ? '0 : load_v;
        end else if (state_q == StResp) begin
            err_d   = 1'b0;
            rdata_d = '0;
        end
    end

    // Array has no reset so contents survive rst_n; async reset leaves StAccess before this edge
    always_ff @(posedge clk) begin
        if (state_q == StAccess && we_q && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_mem.sv
// Scoreboard bench for sd_mem: two instances (WAIT=0 and WAIT=3) share stimulus; a byte-array
// model predicts each response and a negedge monitor checks ack timing, data, err and ready.
module tb_sd_mem;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned W0    = 0;
    localparam int unsigned W1    = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic        sext  = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  size  = '0;

    logic        ready0, ack0, err0, ready1, ack1, err1;
    logic [31:0] rdata0, rdata1;

    sd_mem #(.DEPTH(DEPTH), .WAIT(W0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .size(size),
        .sext(sext), .wdata(wdata), .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0)
    );

    sd_mem #(.DEPTH(DEPTH), .WAIT(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .size(size),
        .sext(sext), .wdata(wdata), .ready(ready1), .ack(ack1), .rdata(rdata1), .err(err1)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned acc;
        int unsigned ackc;
        logic [31:0] rd;
        logic        er;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [7:0] mem_m [4*DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference: a byte-addressed array, accesses of 1/2/4 bytes at the naturally aligned base
    function automatic void model(input logic w, input logic [31:0] a, input logic [1:0] sz,
                                  input logic sx, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int unsigned n, base;
        logic [31:0] v;
        n    = 1 << sz;
        base = a & ~(n - 1);
        er   = (a >= 4 * DEPTH) || (sz == 2'b11);
`ifdef SD_MISALIGN_EN
        if (sz != 2'b11 && (a % n) != 0) er = 1'b1;
`endif
        rd = '0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < int'(n); i++) mem_m[base + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < int'(n); i++) v |= 32'(mem_m[base + i]) << (8 * i);
                if (sx && n == 1 && v[7])  v |= 32'hFFFF_FF00;
                if (sx && n == 2 && v[15]) v |= 32'hFFFF_0000;
                rd = v;
            end
        end
    endfunction

    task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic sx, input logic [31:0] wd, input logic apply,
                         input logic use_k, input logic [31:0] k_rd, input logic k_er);
        int n;
        logic [31:0] rd;
        logic er;
        exp_t e;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(ready0 && ready1) && n < 50);
        if (!(ready0 && ready1)) begin
            chk("ready_timeout", 32'(ready0 && ready1), 32'd1);
            return;
        end
        we    = w;
        addr  = a;
        size  = sz;
        sext  = sx;
        wdata = wd;
        req   = 1'b1;
        if (apply) begin
            model(w, a, sz, sx, wd, rd, er);
            if (use_k) begin
                rd = k_rd;
                er = k_er;
            end
            e.acc  = cyc + 1;
            e.rd   = rd;
            e.er   = er;
            e.ackc = cyc + 1 + W0 + 1;
            q0.push_back(e);
            e.ackc = cyc + 1 + W1 + 1;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
        req   = 1'b0;
        we    = 1'($urandom);
        addr  = $urandom;
        size  = 2'($urandom);
        sext  = 1'($urandom);
        wdata = $urandom;
    endtask

    task automatic acc(input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic sx, input logic [31:0] wd);
        issue(w, a, sz, sx, wd, 1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic acck(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic sx, input logic [31:0] wd, input logic [31:0] k_rd,
                        input logic k_er);
        issue(w, a, sz, sx, wd, 1'b1, 1'b1, k_rd, k_er);
    endtask

    task automatic mon(input int d, input logic rdy, input logic ak, input logic [31:0] rd,
                       input logic er);
        exp_t h;
        logic has;
        h   = '{acc: 0, ackc: 0, rd: 32'd0, er: 1'b0};
        has = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (has) begin
            if (d == 0) h = q0[0];
            else        h = q1[0];
        end
        chk($sformatf("ready%0d", d), 32'(rdy), 32'(rst_n && !(has && h.acc <= cyc)));
        if (ak) begin
            if (!has) begin
                chk($sformatf("ack_unexpected%0d", d), 32'd1, 32'd0);
            end else begin
                if (d == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                chk($sformatf("ack_cycle%0d", d), cyc, h.ackc);
                chk($sformatf("rdata%0d", d), rd, h.rd);
                chk($sformatf("err%0d", d), 32'(er), 32'(h.er));
            end
        end else begin
            chk($sformatf("idle_rdata%0d", d), rd, 32'd0);
            chk($sformatf("idle_err%0d", d), 32'(er), 32'd0);
            if (has && cyc >= h.ackc) begin
                chk($sformatf("ack_missing%0d", d), 32'd0, 32'd1);
                if (d == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ready0, ack0, rdata0, err0);
        mon(1, ready1, ack1, rdata1, err1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] a;
        logic [1:0]  sz;
        int r;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < int'(DEPTH); i++) acc(1'b1, 32'(i * 4), 2'b10, 1'b0, $urandom);

        acck(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
        acck(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);

        acc(1'b1, 32'h10, 2'b10, 1'b0, 32'h0);
        acc(1'b1, 32'h11, 2'b00, 1'b0, 32'h0000_0080);
        acck(1'b0, 32'h11, 2'b00, 1'b1, 32'h0, 32'hFFFF_FF80, 1'b0);
        acck(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, 32'h0000_0080, 1'b0);
        acck(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h0000_8000, 1'b0);

        acck(1'b0, 32'h400, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        acck(1'b1, 32'h400, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 1'b1);
        acc(1'b0, 32'h0, 2'b10, 1'b0, 32'h0);

        acc(1'b1, 32'h10, 2'b10, 1'b0, 32'hA1B2_C3D4);
`ifdef SD_MISALIGN_EN
        acck(1'b0, 32'h12, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
`else
        acck(1'b0, 32'h12, 2'b10, 1'b0, 32'h0, 32'hA1B2_C3D4, 1'b0);
`endif
        acc(1'b0, 32'h12, 2'b01, 1'b1, 32'h0);
        acck(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
        acc(1'b1, 32'h3FE, 2'b01, 1'b0, 32'h0000_9ABC);
        acc(1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0);

        // Abort a byte store in flight: DUT0 is in its access cycle, DUT1 is waiting
        acc(1'b1, 32'h20, 2'b10, 1'b0, 32'h0);
        issue(1'b1, 32'h20, 2'b00, 1'b0, 32'h55, 1'b0, 1'b0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        acck(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);

        repeat (300) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(4 * DEPTH + $urandom_range(0, 15));
            else             a = 32'($urandom_range(0, 4 * DEPTH - 1));
            r  = $urandom_range(0, 9);
            sz = (r == 9) ? 2'b11 : 2'(r % 3);
            acc(1'($urandom), a, sz, 1'($urandom), $urandom);
        end

        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (q0.size() > 0 || q1.size() > 0) chk("drain_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
